// File: rtl/weight_line_packer.sv
// rtl/weight_line_packer.sv - packs narrow DMA weight beats into BRAM-width lines, framing blocks with tlast
module weight_line_packer #(
  parameter int IN_WIDTH    = 64,
  parameter int OUT_WIDTH   = 256,
  parameter int ADDRS_WIDTH = 10
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [ADDRS_WIDTH-1:0] write_depth,
  input  logic [IN_WIDTH-1:0]    s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [15:0]            blocks_sent,
  output logic                   err_tlast
);
  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

  logic [OUT_WIDTH-IN_WIDTH-1:0] asm_buf;
  logic [CW-1:0]                 asm_cnt;
  logic [ADDRS_WIDTH-1:0]        line_cnt;
  logic [ADDRS_WIDTH-1:0]        depth_q;
  logic                          last_beat;
  logic                          line_end;
  logic                          block_start;
  logic                          accept;
  logic                          complete;
  logic                          drain;

  assign last_beat   = (asm_cnt == LAST_BEAT);
  assign line_end    = (line_cnt == depth_q);
  assign block_start = (asm_cnt == '0) && (line_cnt == '0);
  // Only the completing beat can stall, and only while the held line is not draining.
  assign s_axis_tready = ~last_beat | ~m_axis_tvalid | m_axis_tready;
  assign accept      = s_axis_tvalid & s_axis_tready;
  assign complete    = accept & last_beat;
  assign drain       = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      asm_buf       <= '0;
      asm_cnt       <= '0;
      line_cnt      <= '0;
      depth_q       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      blocks_sent   <= '0;
      err_tlast     <= 1'b0;
    end else begin
      if (accept) begin
        // The completing beat never coincides with block start, so depth_q is settled by then.
        if (block_start) depth_q <= write_depth;
        if (last_beat) begin
          asm_cnt  <= '0;
          line_cnt <= line_end ? '0 : line_cnt + 1'b1;
        end else begin
          asm_cnt <= asm_cnt + 1'b1;
          for (int k = 0; k < RATIO - 1; k++) begin
            if (asm_cnt == CW'(k)) asm_buf[k*IN_WIDTH +: IN_WIDTH] <= s_axis_tdata;
          end
        end
        if (s_axis_tlast != (last_beat && line_end)) err_tlast <= 1'b1;
      end
      if (complete) begin
        m_axis_tdata  <= {s_axis_tdata, asm_buf};
        m_axis_tlast  <= line_end;
        m_axis_tvalid <= 1'b1;
      end else if (drain) begin
        m_axis_tvalid <= 1'b0;
      end
      if (drain && m_axis_tlast) blocks_sent <= blocks_sent + 1'b1;
    end
  end
endmodule

// File: tb/tb_weight_line_packer.sv
// tb/tb_weight_line_packer.sv - randomized self-checking bench for weight_line_packer
module tb_weight_line_packer;
  localparam int IW = 64;
  localparam int OW = 256;
  localparam int AW = 10;
  localparam int R  = OW / IW;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [AW-1:0] write_depth = 10'd2;
  logic [IW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [OW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [15:0]   blocks_sent;
  logic          err_tlast;

  weight_line_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .ADDRS_WIDTH(AW)) dut (
    .aclk(aclk), .areset(areset), .write_depth(write_depth),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .blocks_sent(blocks_sent),
    .err_tlast(err_tlast)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int ready_mode = 0;
  int exp_blocks = 0;

  logic [IW-1:0] bq_d[$];
  logic          bq_l[$];
  logic [OW-1:0] exp_d[$];
  logic          exp_l[$];
  logic [OW-1:0] got_d[$];
  logic          got_l[$];
  int            hs_cyc[$];

  always @(posedge aclk) cyc++;

  always @(posedge aclk) begin
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  always @(negedge aclk) begin
    if (!areset) begin
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
        hs_cyc.push_back(cyc);
      end
      if (s_axis_tvalid && s_axis_tready) acc_cnt++;
    end
  end

  task automatic clear_q();
    bq_d.delete(); bq_l.delete(); exp_d.delete(); exp_l.delete();
    got_d.delete(); got_l.delete(); hs_cyc.delete();
    acc_cnt = 0;
  endtask

  // Reference: a block of depth+1 lines, R beats each, beat k of a line in slot k, tlast on its final beat.
  task automatic gen_block(int depth, bit seq);
    logic [OW-1:0] line;
    logic [IW-1:0] b;
    for (int l = 0; l <= depth; l++) begin
      line = '0;
      for (int k = 0; k < R; k++) begin
        b = seq ? IW'(bq_d.size()) : {$urandom, $urandom};
        line[k*IW +: IW] = b;
        bq_d.push_back(b);
        bq_l.push_back(l == depth && k == R - 1);
      end
      exp_d.push_back(line);
      exp_l.push_back(l == depth);
    end
  endtask

  task automatic drive(int first, int last_i, int gap_max, int chg_idx, int chg_val);
    int g;
    int t;
    bit ok;
    for (int i = first; i <= last_i; i++) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (g > 0) begin
        s_axis_tvalid = 1'b0;
        repeat (g) begin @(posedge aclk); #1; end
      end
      s_axis_tdata = bq_d[i];
      s_axis_tlast = bq_l[i];
      s_axis_tvalid = 1'b1;
      ok = 1'b0;
      t = 0;
      while (!ok && t < 2000) begin
        @(negedge aclk);
        ok = s_axis_tready;
        @(posedge aclk); #1;
        t++;
      end
      if (!ok) begin
        checks++;
        $display("FAIL drive_timeout beat %0d got no tready required tready=1", i);
        s_axis_tvalid = 1'b0;
        return;
      end
      if (i == chg_idx) write_depth = AW'(chg_val);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic wait_lines(int n);
    int t = 0;
    while (got_d.size() < n && t < 3000) begin @(posedge aclk); #1; t++; end
    repeat (4) begin @(posedge aclk); #1; end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (s_axis_tready !== 1'b1) $display("FAIL rst_s_tready got %b required 1", s_axis_tready); else passed++;
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_m_tvalid got %b required 0", m_axis_tvalid); else passed++;
    checks++; if (m_axis_tlast !== 1'b0) $display("FAIL rst_m_tlast got %b required 0", m_axis_tlast); else passed++;
    checks++; if (m_axis_tdata !== '0) $display("FAIL rst_m_tdata got %h required 0", m_axis_tdata); else passed++;
    checks++; if (blocks_sent !== 16'd0) $display("FAIL rst_blocks got %0d required 0", blocks_sent); else passed++;
    checks++; if (err_tlast !== 1'b0) $display("FAIL rst_err got %b required 0", err_tlast); else passed++;
    areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_basic();
    clear_q();
    ready_mode = 0;
    write_depth = 10'd2;
    gen_block(2, 1'b1);
    exp_blocks += 1;
    drive(0, 11, 0, -1, 0);
    wait_lines(3);
    checks++; if (got_d.size() != 3) $display("FAIL basic_count got %0d required 3", got_d.size()); else passed++;
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL basic_line%0d got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passed++;
    end
    checks++; if (blocks_sent !== 16'(exp_blocks)) $display("FAIL basic_blocks got %0d required %0d", blocks_sent, exp_blocks); else passed++;
    checks++; if (err_tlast !== 1'b0) $display("FAIL basic_err got %b required 0", err_tlast); else passed++;
  endtask

  task automatic test_backpressure();
    clear_q();
    ready_mode = 2;
    repeat (2) begin @(posedge aclk); #1; end
    gen_block(2, 1'b0);
    gen_block(2, 1'b0);
    exp_blocks += 2;
    fork
      drive(0, 23, 0, -1, 0);
      begin
        repeat (6) @(posedge aclk);
        #2;
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[0] || m_axis_tlast !== 1'b0)
          $display("FAIL bp_hold_early got %b/%h/%b required 1/%h/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_d[0]);
        else passed++;
        repeat (10) @(posedge aclk);
        #2;
        checks++; if (acc_cnt != 7) $display("FAIL bp_accepted got %0d required 7", acc_cnt); else passed++;
        checks++; if (s_axis_tready !== 1'b0) $display("FAIL bp_s_tready got %b required 0", s_axis_tready); else passed++;
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[0] || m_axis_tlast !== 1'b0)
          $display("FAIL bp_hold_late got %b/%h/%b required 1/%h/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_d[0]);
        else passed++;
        ready_mode = 1;
      end
    join
    ready_mode = 0;
    wait_lines(6);
    checks++; if (got_d.size() != 6) $display("FAIL bp_count got %0d required 6", got_d.size()); else passed++;
    for (int i = 0; i < 6 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL bp_line%0d got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passed++;
    end
    checks++; if (blocks_sent !== 16'(exp_blocks)) $display("FAIL bp_blocks got %0d required %0d", blocks_sent, exp_blocks); else passed++;
  endtask

  task automatic test_full_rate();
    int bad_gap = 0;
    clear_q();
    ready_mode = 0;
    repeat (2) begin @(posedge aclk); #1; end
    write_depth = 10'd2;
    for (int b = 0; b < 3; b++) gen_block(2, 1'b0);
    exp_blocks += 3;
    drive(0, 35, 0, -1, 0);
    wait_lines(9);
    checks++; if (got_d.size() != 9) $display("FAIL rate_count got %0d required 9", got_d.size()); else passed++;
    for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != R) bad_gap++;
    checks++; if (bad_gap != 0) $display("FAIL rate_gaps got %0d irregular gaps required 0", bad_gap); else passed++;
    for (int i = 0; i < 9 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL rate_line%0d got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passed++;
    end
    checks++; if (blocks_sent !== 16'(exp_blocks)) $display("FAIL rate_blocks got %0d required %0d", blocks_sent, exp_blocks); else passed++;
  endtask

  task automatic test_depth_latch();
    clear_q();
    ready_mode = 1;
    write_depth = 10'd2;
    gen_block(2, 1'b0);
    gen_block(0, 1'b0);
    gen_block(0, 1'b0);
    exp_blocks += 3;
    drive(0, bq_d.size() - 1, 2, 0, 0);
    ready_mode = 0;
    wait_lines(5);
    checks++; if (got_d.size() != 5) $display("FAIL depth_count got %0d required 5", got_d.size()); else passed++;
    for (int i = 0; i < 5 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL depth_line%0d got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passed++;
    end
    checks++; if (blocks_sent !== 16'(exp_blocks)) $display("FAIL depth_blocks got %0d required %0d", blocks_sent, exp_blocks); else passed++;
    checks++; if (err_tlast !== 1'b0) $display("FAIL depth_err got %b required 0", err_tlast); else passed++;
  endtask

  task automatic test_framing();
    clear_q();
    ready_mode = 1;
    write_depth = 10'd2;
    gen_block(2, 1'b0);
    bq_l[5] = 1'b1;
    exp_blocks += 1;
    drive(0, 4, 1, -1, 0);
    checks++; if (err_tlast !== 1'b0) $display("FAIL frame_err_before got %b required 0", err_tlast); else passed++;
    drive(5, 5, 0, -1, 0);
    checks++; if (err_tlast !== 1'b1) $display("FAIL frame_err_set got %b required 1", err_tlast); else passed++;
    drive(6, 11, 1, -1, 0);
    ready_mode = 0;
    wait_lines(3);
    checks++; if (got_d.size() != 3) $display("FAIL frame_count got %0d required 3", got_d.size()); else passed++;
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL frame_line%0d got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passed++;
    end
    checks++; if (err_tlast !== 1'b1) $display("FAIL frame_err_sticky got %b required 1", err_tlast); else passed++;
    checks++; if (blocks_sent !== 16'(exp_blocks)) $display("FAIL frame_blocks got %0d required %0d", blocks_sent, exp_blocks); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_q();
    ready_mode = 2;
    repeat (2) begin @(posedge aclk); #1; end
    gen_block(2, 1'b0);
    drive(0, 5, 0, -1, 0);
    #2 areset = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rmid_m_tvalid got %b required 0", m_axis_tvalid); else passed++;
    checks++; if (m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) $display("FAIL rmid_m_data got %h/%b required 0/0", m_axis_tdata, m_axis_tlast); else passed++;
    checks++; if (s_axis_tready !== 1'b1) $display("FAIL rmid_s_tready got %b required 1", s_axis_tready); else passed++;
    checks++; if (blocks_sent !== 16'd0) $display("FAIL rmid_blocks got %0d required 0", blocks_sent); else passed++;
    checks++; if (err_tlast !== 1'b0) $display("FAIL rmid_err got %b required 0", err_tlast); else passed++;
    @(posedge aclk); #1;
    areset = 1'b0;
    ready_mode = 0;
    clear_q();
    exp_blocks = 1;
    gen_block(2, 1'b0);
    @(posedge aclk); #1;
    drive(0, 11, 1, -1, 0);
    wait_lines(3);
    checks++; if (got_d.size() != 3) $display("FAIL rmid_count got %0d required 3", got_d.size()); else passed++;
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL rmid_line%0d got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else passed++;
    end
    checks++; if (blocks_sent !== 16'(exp_blocks)) $display("FAIL rmid_blocks_after got %0d required %0d", blocks_sent, exp_blocks); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_full_rate();
    test_depth_latch();
    test_framing();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/weight_line_packer.md
# weight_line_packer

Transmit-side feeder for the weight rotator's AXI-stream input. It accepts narrow weight beats from the DMA and packs them into full BRAM-width weight lines. It emits each block of write_depth+1 lines (bias line first, then K_size*CH_in weight lines) on an AXI-stream master and marks the last line of every block with tlast. It sits between the weight DMA and the weight rotator and sustains one output line per RATIO input beats with no bubbles.

## Interface
- IN_WIDTH, 64: DMA beat width in bits.
- OUT_WIDTH, 256: weight line width (BRAM_WIDTH); must be an integer multiple of IN_WIDTH. RATIO = OUT_WIDTH/IN_WIDTH ≥ 2.
- ADDRS_WIDTH, 10: width of write_depth.
- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- write_depth  in  ADDRS_WIDTH  lines per block minus 1; sampled at block start only.
- s_axis_tdata  in  IN_WIDTH  weight beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  DMA end-of-block marker; checked only, never used for framing.
- s_axis_tready  out  1  beat accepted when tvalid&tready.
- m_axis_tdata  out  OUT_WIDTH  packed weight line.
- m_axis_tvalid  out  1  line valid.
- m_axis_tlast  out  1  last line of block.
- m_axis_tready  in  1  downstream (rotator) ready.
- blocks_sent  out  16  count of completed blocks; wraps at 2^16.
- err_tlast  out  1  sticky framing error.

## Operation
- Registers: assembly buffer (OUT_WIDTH-IN_WIDTH bits), beat counter asm_cnt (0..RATIO-1), line counter line_cnt (0..depth_q), latched depth_q, output register with tdata/tlast, valid flag.
- Packing is little-endian. The beat with asm_cnt=k lands in bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
- Block start: the beat accepted with asm_cnt==0 and line_cnt==0 latches depth_q <= write_depth in the same cycle. A write_depth change mid-block has no effect.
- Beats with asm_cnt<RATIO-1 are stored in the buffer, and asm_cnt increments.
- The beat with asm_cnt==RATIO-1 completes the line. Next cycle, the output register holds {beat, buffer} with tlast=(line_cnt==depth_q). asm_cnt then goes to 0. line_cnt goes to 0 if it was at depth_q, else line_cnt+1.
- s_axis_tready = (asm_cnt != RATIO-1) | ~m_axis_tvalid | m_axis_tready. Partial beats are never stalled. The completing beat stalls only while the output register is full and not draining.
- Output register: set on line completion; cleared on m_axis handshake without a simultaneous completion. A completion in the same cycle as an output handshake reloads the register, keeping tvalid high.
- m_axis_tdata and m_axis_tlast hold stable while tvalid & ~tready.
- blocks_sent increments on m_axis handshake with m_axis_tlast=1.
- err_tlast is set, and stays set until reset, when either:
  - an accepted beat has s_axis_tlast=1 and is not the final beat of the block (asm_cnt!=RATIO-1 or line_cnt!=depth_q); or
  - the final beat of the block has s_axis_tlast=0.
- Framing is unaffected by err_tlast; counters are not resynchronised.
- write_depth=0 is legal: every line is a 1-line block with tlast=1.

## Timing
- Reset values: s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, blocks_sent=0, err_tlast=0. Internal asm_cnt, line_cnt and depth_q are 0.
- Reset asserted mid-block discards the partial line and any pending output line. The first beat after deassertion starts a new block.
- Latency: completing beat accepted at edge N gives m_axis_tvalid=1 after edge N.
- Throughput: one line per RATIO cycles with continuous tvalid and tready.
- Backpressure: with tready low, the packer buffers exactly one full line plus RATIO-1 partial beats, then s_axis_tready drops.
- No combinational path from s_axis_tvalid to m_axis_tvalid. The only combinational path is m_axis_tready to s_axis_tready.

## Test plan
All scenarios use IN_WIDTH=64, OUT_WIDTH=256 (RATIO=4), write_depth=2.
- Basic pack: 12 beats with values 0..11, tlast on beat 11, tready=1 -> 3 lines. Line0 = {3,2,1,0} (beat 0 in LSBs). tlast only on line2. blocks_sent=1. err_tlast=0.
- Backpressure: m_axis_tready=0 while streaming -> s_axis_tready low after 7 accepted beats (4 in the held line, 3 in the buffer). tdata/tlast stable. Release tready -> no loss or duplication, order preserved.
- Full-rate overlap: continuous valid and ready over 3 blocks -> m_axis_tvalid pattern 1-in-4 with no gaps. blocks_sent=3.
- Depth latch: change write_depth from 2 to 0 after the first beat of a block -> that block still has 3 lines. The following blocks are 1 line each, with tlast on every line.
- Framing error: s_axis_tlast on beat 5 -> err_tlast=1 from the next cycle and it stays set. Output lines and tlast positions are unchanged.
- Reset mid-line: areset after 6 beats -> all outputs at reset values asynchronously. A fresh 12-beat block then yields 3 correct lines.
